conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_sequencer
// Description : Walks a kernel_size x kernel_size window across a
//               data_width x data_height feature map in row-major order.
//               Each window position is offered to the linebuffer with a
//               valid/ready handshake. The sequencer then waits for the PE
//               to report a result and emits a write strobe for that
//               result's output slot.
//
// Ports       : clock      - sole clock, rising edge
//               reset      - asynchronous, active-low
//               start      - one-cycle pass request (honoured only in IDLE)
//               abort      - pass abort (only when CONV_SEQ_ABORT_EN defined)
//               win_valid  - window position valid for the linebuffer
//               win_ready  - linebuffer accepts the window position
//               win_row    - top row of the current window
//               win_col    - left column of the current window
//               pe_done    - PE result ready for the accepted window
//               res_wr     - one-cycle result write strobe
//               res_idx    - row-major output slot index
//               busy       - pass in progress
//               done       - one-cycle end-of-pass pulse
//               proto_err  - sticky: pe_done seen outside WAIT
//
// Options     : CONV_SEQ_ABORT_EN - adds the abort input
// Revision    : 1.0 - initial release
// ============================================================================
module conv_sequencer #(
  parameter int kernel_size = 2,
  parameter int data_width  = 4,
  parameter int data_height = 4,
  localparam int OW = data_width - kernel_size + 1,
  localparam int OH = data_height - kernel_size + 1,
  localparam int N  = OW * OH,
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int RW = ($clog2(OH) > 1) ? $clog2(OH) : 1,
  localparam int XW = ($clog2(OW) > 1) ? $clog2(OW) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
`ifdef CONV_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [XW-1:0] win_col,
  input  logic          pe_done,
  output logic          res_wr,
  output logic [CW-1:0] res_idx,
  output logic          busy,
  output logic          done,
  output logic          proto_err
);

  localparam logic [CW-1:0] c_LAST_IDX = CW'(N - 1);
  localparam logic [XW-1:0] c_LAST_COL = XW'(OW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [XW-1:0] r_col;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_res_idx;
  logic          r_win_valid;
  logic          r_busy;
  logic          r_res_wr;
  logic          r_done;
  logic          r_proto_err;
  logic          w_abort;

`ifdef CONV_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_count     <= '0;
      r_res_idx   <= '0;
      r_win_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_res_wr    <= 1'b0;
      r_done      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_res_wr <= 1'b0;
      r_done   <= 1'b0;

      // A PE completion outside WAIT has no window to belong to.
      if (pe_done && (r_state != S_WAIT)) begin
        r_proto_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row       <= '0;
            r_col       <= '0;
            r_count     <= '0;
            r_win_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
            // Accepted start clears the flag unless a stray pe_done
            // arrives in this very cycle.
            r_proto_err <= pe_done;
          end
        end

        S_ISSUE: begin
          if (w_abort) begin
            r_row       <= '0;
            r_col       <= '0;
            r_count     <= '0;
            r_win_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (win_ready) begin
            r_win_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_abort) begin
            r_row   <= '0;
            r_col   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (pe_done) begin
            r_res_wr  <= 1'b1;
            r_res_idx <= r_count;
            if (r_count == c_LAST_IDX) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_count <= r_count + CW'(1);
              if (r_col == c_LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + RW'(1);
              end else begin
                r_col <= r_col + XW'(1);
              end
              // Next window is offered in the same cycle as this write.
              r_win_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_win_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign win_valid = r_win_valid;
  assign win_row   = r_row;
  assign win_col   = r_col;
  assign res_wr    = r_res_wr;
  assign res_idx   = r_res_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign proto_err = r_proto_err;

endmodule
`default_nettype wire
